sim_memory_arbiter: RTL

//  Two-requester arbiter in front of sim_memory_model; sits between port 0 (instruction fetch) and port 1 (data load/store).

---
 rtl/sim_memory_arbiter_pkg.sv | 20 ++
 rtl/mist1032isa_sync_fifo.sv | 56 +++++
 rtl/sim_memory_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/sim_memory_arbiter_pkg.sv
// Shared constants and request bundle type for the two-port memory arbiter.
package sim_memory_arbiter_pkg;

    localparam logic [1:0] L_PARAM_ORDER_BYTE = 2'b00;
    localparam logic [1:0] L_PARAM_ORDER_HALF = 2'b01;
    localparam logic [1:0] L_PARAM_ORDER_WORD = 2'b10;

    localparam logic L_PORT_INST = 1'b0;
    localparam logic L_PORT_DATA = 1'b1;

    typedef struct packed {
        logic        req;
        logic [1:0]  order;
        logic [3:0]  mask;
        logic        rw;
        logic [25:0] addr;
        logic [31:0] data;
    } mem_req_t;

endpackage

// File: rtl/mist1032isa_sync_fifo.sv
// Single-clock FIFO with combinational head output; DEPTH must equal 2**DEPTH_N.
module mist1032isa_sync_fifo #(
    parameter int unsigned N       = 1,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned DEPTH_N = 3
)(
    input  logic         iCLOCK,
    input  logic         inRESET,
    input  logic         iWR_EN,
    input  logic [N-1:0] iWR_DATA,
    output logic         oWR_FULL,
    input  logic         iRD_EN,
    output logic [N-1:0] oRD_DATA,
    output logic         oRD_EMPTY
);

    logic [N-1:0]       mem_q [DEPTH];
    logic [DEPTH_N-1:0] wr_ptr_q;
    logic [DEPTH_N-1:0] rd_ptr_q;
    logic [DEPTH_N:0]   count_q;
    logic               do_wr;
    logic               do_rd;

    assign oWR_FULL  = (count_q == (DEPTH_N + 1)'(DEPTH));
    assign oRD_EMPTY = (count_q == '0);
    assign oRD_DATA  = mem_q[rd_ptr_q];

    // Requests against a full/empty FIFO are ignored rather than corrupting state.
    assign do_wr = iWR_EN && !oWR_FULL;
    assign do_rd = iRD_EN && !oRD_EMPTY;

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= iWR_DATA;
                wr_ptr_q        <= wr_ptr_q + DEPTH_N'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + DEPTH_N'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + (DEPTH_N + 1)'(1);
                2'b01:   count_q <= count_q - (DEPTH_N + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sim_memory_arbiter.sv
// Two-port arbiter in front of the memory model: round-robin grant, in-order read return
// steered to the issuing port via a tag FIFO.
module sim_memory_arbiter
    import sim_memory_arbiter_pkg::*;
#(
    parameter int unsigned P_TAG_DEPTH   = 8,
    parameter int unsigned P_TAG_DEPTH_N = 3,
    parameter bit          P_FIXED_PRI   = 1'b0
)(
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iRQ0_REQ,
    output logic        oRQ0_LOCK,
    input  logic [1:0]  iRQ0_ORDER,
    input  logic [3:0]  iRQ0_MASK,
    input  logic        iRQ0_RW,
    input  logic [25:0] iRQ0_ADDR,
    input  logic [31:0] iRQ0_DATA,
    output logic        oRQ0_VALID,
    input  logic        iRQ0_LOCK,
    output logic [63:0] oRQ0_DATA,
    input  logic        iRQ1_REQ,
    output logic        oRQ1_LOCK,
    input  logic [1:0]  iRQ1_ORDER,
    input  logic [3:0]  iRQ1_MASK,
    input  logic        iRQ1_RW,
    input  logic [25:0] iRQ1_ADDR,
    input  logic [31:0] iRQ1_DATA,
    output logic        oRQ1_VALID,
    input  logic        iRQ1_LOCK,
    output logic [63:0] oRQ1_DATA,
    output logic        oMEMORY_REQ,
    output logic [1:0]  oMEMORY_ORDER,
    output logic [3:0]  oMEMORY_MASK,
    output logic        oMEMORY_RW,
    output logic [25:0] oMEMORY_ADDR,
    output logic [31:0] oMEMORY_DATA,
    input  logic        iMEMORY_LOCK,
    input  logic        iMEMORY_VALID,
    output logic        oMEMORY_LOCK,
    input  logic [63:0] iMEMORY_DATA,
    output logic        oERROR
);

    mem_req_t rq0;
    mem_req_t rq1;
    mem_req_t rq_g;
    logic     grant;
    logic     accept;
    logic     last_grant_q;
    logic     error_q;
    logic     tag_full;
    logic     tag_empty;
    logic     tag_head;
    logic     tag_push;
    logic     tag_pop;

    assign rq0 = {iRQ0_REQ, iRQ0_ORDER, iRQ0_MASK, iRQ0_RW, iRQ0_ADDR, iRQ0_DATA};
    assign rq1 = {iRQ1_REQ, iRQ1_ORDER, iRQ1_MASK, iRQ1_RW, iRQ1_ADDR, iRQ1_DATA};

    always_comb begin
        grant = L_PORT_INST;
        if (iRQ0_REQ && iRQ1_REQ) begin
            grant = P_FIXED_PRI ? L_PORT_INST : ~last_grant_q;
        end else if (iRQ1_REQ) begin
            grant = L_PORT_DATA;
        end
    end

    assign rq_g = (grant == L_PORT_DATA) ? rq1 : rq0;

    // A full tag FIFO blocks reads even when a pop happens in the same cycle.
    assign accept = rq_g.req && !iMEMORY_LOCK && !(!rq_g.rw && tag_full);

    assign oMEMORY_REQ   = accept;
    assign oMEMORY_ORDER = rq_g.order;
    assign oMEMORY_MASK  = rq_g.mask;
    assign oMEMORY_RW    = rq_g.rw;
    assign oMEMORY_ADDR  = rq_g.addr;
    assign oMEMORY_DATA  = rq_g.data;

    assign oRQ0_LOCK = !(accept && (grant == L_PORT_INST));
    assign oRQ1_LOCK = !(accept && (grant == L_PORT_DATA));

    assign tag_push = accept && !rq_g.rw;
    assign tag_pop  = iMEMORY_VALID && !tag_empty;

    mist1032isa_sync_fifo #(
        .N       (1),
        .DEPTH   (P_TAG_DEPTH),
        .DEPTH_N (P_TAG_DEPTH_N)
    ) u_tag_fifo (
        .iCLOCK    (iCLOCK),
        .inRESET   (inRESET),
        .iWR_EN    (tag_push),
        .iWR_DATA  (grant),
        .oWR_FULL  (tag_full),
        .iRD_EN    (tag_pop),
        .oRD_DATA  (tag_head),
        .oRD_EMPTY (tag_empty)
    );

    // The head requester's back-pressure stalls all returns; memory is strictly in order.
    assign oMEMORY_LOCK = !tag_empty && ((tag_head == L_PORT_DATA) ? iRQ1_LOCK : iRQ0_LOCK);

    assign oRQ0_VALID = iMEMORY_VALID && !tag_empty && (tag_head == L_PORT_INST);
    assign oRQ1_VALID = iMEMORY_VALID && !tag_empty && (tag_head == L_PORT_DATA);
    assign oRQ0_DATA  = iMEMORY_DATA;
    assign oRQ1_DATA  = iMEMORY_DATA;
    assign oERROR     = error_q;

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            last_grant_q <= L_PORT_DATA;
            error_q      <= 1'b0;
        end else begin
            if (accept) begin
                last_grant_q <= grant;
            end
            if (iMEMORY_VALID && tag_empty) begin
                error_q <= 1'b1;
            end
        end
    end

endmodule
